rgb2gray_engine: RTL and testbench
==================================

// Module: rgb2gray_engine
// PURPOSE
//  Parametrised colour-to-gray conversion engine between the colour BRAM (AXI-filled) and the gray BRAM.
//  On i_START it reads every pixel once, converts it with a run-time mode and writes one gray word per pixel.
//  o_STATE reports progress to the processor. Generalises the fixed 320x240 RGB444->8-bit converter.
// PARAMETERS
//  R_W      4    red channel width, 1..8
//  G_W      4    green channel width, 1..8
//  B_W      4    blue channel width, 1..8
//  GRAY_W   8    gray output width, 1..8
//  N_PIX    76800  pixels per frame (IMG_W*IMG_H), >=1
//  ADDR_W   17   BRAM address width, 2**ADDR_W >= N_PIX
// PORTS
//  i_CLK         in   1               clock, rising edge
//  i_RST         in   1               asynchronous reset, active-high
//  i_START       in   1               start pulse, accepted only in IDLE
//  i_MODE        in   2               00 luma, 01 average, 10 max, 11 green only; sampled with i_START
//  i_HOLD        in   1               stall: freezes address counter and pipeline
//  i_ABORT       in   1               cancel run, return to IDLE
//  i_ACK         in   1               clears DONE -> IDLE
//  o_STATE       out  2               00 IDLE, 01 RUN, 10 FLUSH, 11 DONE
//  o_BUSY        out  1               1 in RUN or FLUSH
//  o_COLOR_ADDR  out  ADDR_W          colour BRAM read address
//  o_COLOR_RDEN  out  1               colour BRAM read enable
//  i_COLOR_DATA  in   R_W+G_W+B_W     {R,G,B}, valid 1 cycle after RDEN
//  o_GRAY_ADDR   out  ADDR_W          gray BRAM write address
//  o_GRAY_WREN   out  1               gray BRAM write enable
//  o_GRAY_DATA   out  GRAY_W          gray pixel
// BEHAVIOUR
//  Reset: o_STATE=00, all enables 0, addresses 0, o_GRAY_DATA 0, o_BUSY 0. Reset mid-run discards pipeline; no partial DONE.
//  FSM: IDLE -(i_START)-> RUN; RUN -(last addr N_PIX-1 issued)-> FLUSH; FLUSH -(last write done)-> DONE;
//   DONE -(i_ACK)-> IDLE. i_ABORT in RUN/FLUSH -> IDLE next cycle, WREN/RDEN 0 that cycle; ignored in IDLE/DONE.
//   i_START outside IDLE ignored. i_ABORT and i_ACK same cycle in DONE: i_ACK wins (both go IDLE).
//  Read: in RUN with i_HOLD=0, RDEN=1 and address increments 0..N_PIX-1, one per cycle, no wrap.
//  Pipeline: S0 issue addr; S1 capture i_COLOR_DATA, expand channels; S2 weight/sum; S3 register WREN/DATA/ADDR.
//   Latency: write of pixel k appears 3 cycles after its read issue; throughput 1 pixel/cycle.
//  i_HOLD=1: RDEN=0, WREN=0, every pipeline stage and counter holds; resume loses/duplicates nothing.
//   Colour BRAM must be configured to hold its output while RDEN=0.
//  Channel expansion: each channel replicated MSB-first to 8 bits (4-bit x -> {x,x}; 5-bit x -> {x,x[4:2]}).
//  Mode 00: Y = (77*R8 + 150*G8 + 29*B8 + 128) >> 8, 17-bit sum, max 255, no overflow.
//  Mode 01: Y = ((R8+G8+B8)*171) >> 9, 10-bit sum, 18-bit product.
//  Mode 10: Y = max(R8,G8,B8). Mode 11: Y = G8.
//  Output: o_GRAY_DATA = Y[7:8-GRAY_W] (truncate, no rounding). o_GRAY_ADDR equals the source read address.
//  Mode held constant for whole run; i_MODE changes during RUN have no effect.
//  Exactly N_PIX writes per completed run; N_PIX=1 passes RUN->FLUSH after one cycle.
// TESTING
//  Defaults, mode 00, pixels 12'hFFF,12'h000,12'hF00,12'h0F0 -> gray 8'hFF,8'h00,8'h4D,8'h95 at addrs 0..3.
//  Mode 01 pixel 12'h111 -> 8'h11; mode 10 pixel 12'h3A5 -> 8'hAA; mode 11 pixel 12'h3A5 -> 8'hAA.
//  Full frame 76800 pixels, data 12'h111+8*i -> 76800 WREN pulses, addr 0..76799, STATE 01->10->11, DONE held until i_ACK.
//  Toggle i_HOLD random 30% during run -> gray BRAM contents identical to no-hold run, write count 76800.
//  i_ABORT at pixel 1000 -> STATE 00 next cycle, no WREN after, i_START restarts from addr 0.
//  i_RST pulse (async, mid-cycle) at pixel 500 -> outputs 0 immediately; GRAY_W=4,R_W=G_W=B_W=5 params: 5'h1F all -> 4'hF.

Source files
------------

// File: rtl/rgb2gray_engine.sv
// Colour-to-gray conversion engine: streams N_PIX {R,G,B} words from the colour
// BRAM, converts each one with a run-time selected mode and writes one gray word
// per pixel to the gray BRAM.
//
// Ports:
//   i_CLK, i_RST            clock (rising edge), asynchronous active-high reset
//   i_START, i_MODE         start pulse (IDLE only); mode sampled with start
//                           (00 luma, 01 average, 10 max, 11 green only)
//   i_HOLD                  stall: freezes address counter and pipeline
//   i_ABORT, i_ACK          cancel a run / acknowledge DONE
//   o_STATE, o_BUSY         00 IDLE, 01 RUN, 10 FLUSH, 11 DONE; busy in RUN/FLUSH
//   o_COLOR_ADDR/_RDEN      colour BRAM read port; i_COLOR_DATA one cycle later
//   o_GRAY_ADDR/_WREN/_DATA gray BRAM write port
module rgb2gray_engine #(
    parameter int R_W    = 4,
    parameter int G_W    = 4,
    parameter int B_W    = 4,
    parameter int GRAY_W = 8,
    parameter int N_PIX  = 76800,
    parameter int ADDR_W = 17
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   i_START,
    input  logic [1:0]             i_MODE,
    input  logic                   i_HOLD,
    input  logic                   i_ABORT,
    input  logic                   i_ACK,
    output logic [1:0]             o_STATE,
    output logic                   o_BUSY,
    output logic [ADDR_W-1:0]      o_COLOR_ADDR,
    output logic                   o_COLOR_RDEN,
    input  logic [R_W+G_W+B_W-1:0] i_COLOR_DATA,
    output logic [ADDR_W-1:0]      o_GRAY_ADDR,
    output logic                   o_GRAY_WREN,
    output logic [GRAY_W-1:0]      o_GRAY_DATA
);

    localparam int CW = R_W + G_W + B_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic                rden_q, rden_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                v1_q, v1_d;
    logic [ADDR_W-1:0]   a1_q, a1_d;
    logic                v2_q, v2_d;
    logic [ADDR_W-1:0]   a2_q, a2_d;
    logic [7:0]          r8_q, r8_d, g8_q, g8_d, b8_q, b8_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [GRAY_W-1:0]   gray_q, gray_d;

    logic                busy;
    logic                abort_run;
    logic [16:0]         sum_l;
    logic [9:0]          sum_a;
    logic [17:0]         prod_a;
    logic [7:0]          mx;
    logic [7:0]          y;

    // Replicate a w-bit channel MSB-first until 8 bits are filled.
    function automatic logic [7:0] expand(input logic [7:0] x, input int w);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[3'(7 - i)] = x[3'(w - 1 - (i % w))];
        end
        return e;
    endfunction

    assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign abort_run = i_ABORT && busy;

    // Gray conversion on the captured, expanded channels.
    always_comb begin
        sum_l  = 17'd77 * 17'(r8_q) + 17'd150 * 17'(g8_q)
               + 17'd29 * 17'(b8_q) + 17'd128;
        sum_a  = 10'(r8_q) + 10'(g8_q) + 10'(b8_q);
        prod_a = 18'(sum_a) * 18'd171;
        mx     = (r8_q > g8_q) ? r8_q : g8_q;
        mx     = (b8_q > mx) ? b8_q : mx;
        case (mode_q)
            2'b00:   y = 8'(sum_l >> 8);
            2'b01:   y = 8'(prod_a >> 9);
            2'b10:   y = mx;
            default: y = g8_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rden_d  = rden_q;
        raddr_d = raddr_q;
        v1_d    = v1_q;
        a1_d    = a1_q;
        v2_d    = v2_q;
        a2_d    = a2_q;
        r8_d    = r8_q;
        g8_d    = g8_q;
        b8_d    = b8_q;
        wren_d  = wren_q;
        waddr_d = waddr_q;
        gray_d  = gray_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_START) begin
                    state_d = S_RUN;
                    mode_d  = i_MODE;
                    rden_d  = 1'b1;
                    raddr_d = '0;
                end
            end
            S_RUN: begin
                if (!i_HOLD) begin
                    if (raddr_q == LAST) begin
                        state_d = S_FLUSH;
                        rden_d  = 1'b0;
                    end else begin
                        raddr_d = raddr_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (!i_HOLD && wren_q && waddr_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ACK) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Whole pipeline advances in lock-step; a stall freezes every stage
        // while the colour BRAM keeps its output because RDEN is low.
        if (!i_HOLD) begin
            v1_d   = rden_q;
            a1_d   = raddr_q;
            v2_d   = v1_q;
            a2_d   = a1_q;
            wren_d = v2_q;
            if (v1_q) begin
                r8_d = expand(8'(i_COLOR_DATA[CW-1 -: R_W]), R_W);
                g8_d = expand(8'(i_COLOR_DATA[B_W +: G_W]), G_W);
                b8_d = expand(8'(i_COLOR_DATA[B_W-1:0]), B_W);
            end
            if (v2_q) begin
                waddr_d = a2_q;
                gray_d  = GRAY_W'(y >> (8 - GRAY_W));
            end
        end

        if (abort_run) begin
            state_d = S_IDLE;
            rden_d  = 1'b0;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
            wren_d  = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            rden_q  <= 1'b0;
            raddr_q <= '0;
            v1_q    <= 1'b0;
            a1_q    <= '0;
            v2_q    <= 1'b0;
            a2_q    <= '0;
            r8_q    <= '0;
            g8_q    <= '0;
            b8_q    <= '0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            gray_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rden_q  <= rden_d;
            raddr_q <= raddr_d;
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            v2_q    <= v2_d;
            a2_q    <= a2_d;
            r8_q    <= r8_d;
            g8_q    <= g8_d;
            b8_q    <= b8_d;
            wren_q  <= wren_d;
            waddr_q <= waddr_d;
            gray_q  <= gray_d;
        end
    end

    // Stall and abort suppress the BRAM strobes in the same cycle.
    assign o_STATE      = state_q;
    assign o_BUSY       = busy;
    assign o_COLOR_ADDR = raddr_q;
    assign o_COLOR_RDEN = rden_q && !i_HOLD && !i_ABORT;
    assign o_GRAY_ADDR  = waddr_q;
    assign o_GRAY_WREN  = wren_q && !i_HOLD && !i_ABORT;
    assign o_GRAY_DATA  = gray_q;

endmodule

// File: tb/tb_rgb2gray_engine.sv
// Directed testbench for rgb2gray_engine: reset, conversion modes, frame
// sequencing, stall, abort, asynchronous reset and parameter variants.
module tb_rgb2gray_engine;

    localparam int NP = 300;

    logic        clk = 1'b0;
    logic        rst, start, hold, abort, ack, clr;
    logic [1:0]  mode;
    logic [1:0]  state;
    logic        busy, crden, gwren;
    logic [8:0]  caddr, gaddr;
    logic [11:0] cdata;
    logic [7:0]  gdata;

    logic        start5, busy5, crden5, gwren5;
    logic [1:0]  state5, caddr5, gaddr5;
    logic [14:0] cdata5;
    logic [3:0]  gdata5;

    logic        start1, busy1, crden1, gwren1;
    logic [1:0]  state1;
    logic [0:0]  caddr1, gaddr1;
    logic [11:0] cdata1;
    logic [7:0]  gdata1;

    int checks = 0;
    int errors = 0;
    int wr_cnt, ord_err, exp_wa;

    logic [11:0] cmem [NP];
    logic [7:0]  gmem [NP];
    logic [7:0]  gold [NP];
    logic [14:0] cmem5 [4];

    always #5 clk = ~clk;

    rgb2gray_engine #(.N_PIX(NP), .ADDR_W(9)) dut (
        .i_CLK(clk), .i_RST(rst), .i_START(start), .i_MODE(mode),
        .i_HOLD(hold), .i_ABORT(abort), .i_ACK(ack),
        .o_STATE(state), .o_BUSY(busy),
        .o_COLOR_ADDR(caddr), .o_COLOR_RDEN(crden), .i_COLOR_DATA(cdata),
        .o_GRAY_ADDR(gaddr), .o_GRAY_WREN(gwren), .o_GRAY_DATA(gdata)
    );

    rgb2gray_engine #(.R_W(5), .G_W(5), .B_W(5), .GRAY_W(4),
                      .N_PIX(4), .ADDR_W(2)) dut5 (
        .i_CLK(clk), .i_RST(rst), .i_START(start5), .i_MODE(mode),
        .i_HOLD(hold), .i_ABORT(abort), .i_ACK(ack),
        .o_STATE(state5), .o_BUSY(busy5),
        .o_COLOR_ADDR(caddr5), .o_COLOR_RDEN(crden5), .i_COLOR_DATA(cdata5),
        .o_GRAY_ADDR(gaddr5), .o_GRAY_WREN(gwren5), .o_GRAY_DATA(gdata5)
    );

    rgb2gray_engine #(.N_PIX(1), .ADDR_W(1)) dut1 (
        .i_CLK(clk), .i_RST(rst), .i_START(start1), .i_MODE(mode),
        .i_HOLD(hold), .i_ABORT(abort), .i_ACK(ack),
        .o_STATE(state1), .o_BUSY(busy1),
        .o_COLOR_ADDR(caddr1), .o_COLOR_RDEN(crden1), .i_COLOR_DATA(cdata1),
        .o_GRAY_ADDR(gaddr1), .o_GRAY_WREN(gwren1), .o_GRAY_DATA(gdata1)
    );

    // Colour BRAMs: registered read, output held while RDEN is low.
    always @(posedge clk) begin
        if (crden)  cdata  <= cmem[caddr];
        if (crden5) cdata5 <= cmem5[caddr5];
        if (crden1) cdata1 <= (caddr1 == 1'b0) ? 12'hF00 : 12'h000;
    end

    // Gray BRAM plus write counter and address-order monitor.
    always @(posedge clk) begin
        if (clr) begin
            wr_cnt  <= 0;
            ord_err <= 0;
            exp_wa  <= 0;
            for (int i = 0; i < NP; i++) gmem[i] <= 8'h00;
        end else if (gwren) begin
            gmem[gaddr] <= gdata;
            wr_cnt      <= wr_cnt + 1;
            if (int'(gaddr) != exp_wa) ord_err <= ord_err + 1;
            exp_wa      <= int'(gaddr) + 1;
        end
    end

    function automatic logic [7:0] ref_luma(input logic [11:0] p);
        int r, g, b;
        r = int'(p[11:8]) * 17;
        g = int'(p[7:4]) * 17;
        b = int'(p[3:0]) * 17;
        return 8'((77 * r + 150 * g + 29 * b + 128) / 256);
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic load_pattern;
        for (int i = 0; i < NP; i++) cmem[i] = 12'h111 + 12'(8 * i);
    endtask

    task automatic do_clr;
        clr = 1'b1;
        tick;
        clr = 1'b0;
    endtask

    task automatic wait_done(input int lim, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (state == 2'b11) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic do_ack;
        ack = 1'b1;
        tick;
        ack = 1'b0;
    endtask

    // Runs one frame; i_MODE is scrambled after start to show it is latched.
    task automatic run_frame(input logic [1:0] m, input int hold_pct,
                             output int run_c, output int flush_c,
                             output logic ok);
        do_clr;
        mode  = m;
        start = 1'b1;
        tick;
        start = 1'b0;
        mode  = ~m;
        run_c = 0;
        flush_c = 0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (state == 2'b11) begin
                ok = 1'b1;
                break;
            end
            if (state == 2'b01) run_c++;
            else if (state == 2'b10) flush_c++;
            hold = (hold_pct > 0) && ($urandom_range(99) < hold_pct);
            tick;
        end
        hold = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        checks++;
        if (state !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%b busy=%b, want 00/0", state, busy);
        end
        checks++;
        if (crden !== 1'b0 || gwren !== 1'b0) begin
            errors++;
            $display("FAIL reset_en: rden=%b wren=%b, want 0/0", crden, gwren);
        end
        checks++;
        if (caddr !== 9'd0 || gaddr !== 9'd0 || gdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: caddr=%0d gaddr=%0d gdata=%h, want 0", caddr, gaddr, gdata);
        end
        checks++;
        if (state5 !== 2'b00 || state1 !== 2'b00) begin
            errors++;
            $display("FAIL reset_variants: s5=%b s1=%b, want 00", state5, state1);
        end
        rst = 1'b0;
        clr = 1'b0;
        tick;
    endtask

    task automatic test_luma;
        logic [7:0] exp_g [4];
        logic ok;
        exp_g = '{8'hFF, 8'h00, 8'h4D, 8'h95};
        cmem[0] = 12'hFFF;
        cmem[1] = 12'h000;
        cmem[2] = 12'hF00;
        cmem[3] = 12'h0F0;
        do_clr;
        mode  = 2'b00;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (state !== 2'b01 || crden !== 1'b1 || caddr !== 9'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL luma_issue: state=%b rden=%b addr=%0d busy=%b, want 01/1/0/1", state, crden, caddr, busy);
        end
        tick;
        tick;
        checks++;
        if (gwren !== 1'b0) begin
            errors++;
            $display("FAIL luma_early_wren: wren=%b, want 0", gwren);
        end
        tick;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (gwren !== 1'b1 || gaddr !== 9'(k) || gdata !== exp_g[k]) begin
                errors++;
                $display("FAIL luma_px%0d: wren=%b addr=%0d data=%h, want 1/%0d/%h", k, gwren, gaddr, gdata, k, exp_g[k]);
            end
            tick;
        end
        wait_done(600, ok);
        checks++;
        if (!ok || wr_cnt !== NP) begin
            errors++;
            $display("FAIL luma_done: done=%b writes=%0d, want 1/%0d", ok, wr_cnt, NP);
        end
        do_ack;
        load_pattern;
    endtask

    task automatic test_modes;
        logic [1:0]  m_v [3];
        logic [11:0] p_v [3];
        logic [7:0]  e_v [3];
        int rc, fc;
        logic ok;
        m_v = '{2'b01, 2'b10, 2'b11};
        p_v = '{12'h111, 12'h3A5, 12'h3A5};
        e_v = '{8'h11, 8'hAA, 8'hAA};
        for (int t = 0; t < 3; t++) begin
            cmem[0] = p_v[t];
            run_frame(m_v[t], 0, rc, fc, ok);
            checks++;
            if (!ok || gmem[0] !== e_v[t]) begin
                errors++;
                $display("FAIL mode%b: done=%b gray=%h, want 1/%h", m_v[t], ok, gmem[0], e_v[t]);
            end
            do_ack;
        end
        load_pattern;
    endtask

    task automatic test_full_frame;
        int rc, fc, bad;
        logic ok;
        run_frame(2'b00, 0, rc, fc, ok);
        checks++;
        if (!ok || rc !== NP || fc !== 3) begin
            errors++;
            $display("FAIL frame_seq: done=%b run=%0d flush=%0d, want 1/%0d/3", ok, rc, fc, NP);
        end
        checks++;
        if (wr_cnt !== NP || ord_err !== 0) begin
            errors++;
            $display("FAIL frame_writes: writes=%0d order_err=%0d, want %0d/0", wr_cnt, ord_err, NP);
        end
        bad = 0;
        for (int i = 0; i < NP; i++) begin
            if (gmem[i] !== ref_luma(cmem[i])) bad++;
            gold[i] = gmem[i];
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL frame_data: bad_pixels=%0d, want 0", bad);
        end
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (state !== 2'b11 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: state=%b busy=%b, want 11/0", state, busy);
        end
        ack   = 1'b1;
        abort = 1'b1;
        tick;
        ack   = 1'b0;
        abort = 1'b0;
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL ack_abort: state=%b, want 00", state);
        end
    endtask

    task automatic test_hold;
        int rc, fc, bad;
        logic ok;
        run_frame(2'b00, 30, rc, fc, ok);
        bad = 0;
        for (int i = 0; i < NP; i++) if (gmem[i] !== gold[i]) bad++;
        checks++;
        if (!ok || wr_cnt !== NP || ord_err !== 0) begin
            errors++;
            $display("FAIL hold_writes: done=%b writes=%0d order_err=%0d, want 1/%0d/0", ok, wr_cnt, ord_err, NP);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_data: bad_pixels=%0d, want 0", bad);
        end
        do_ack;
    endtask

    task automatic test_abort;
        int wc;
        logic ok;
        logic seen;
        do_clr;
        mode  = 2'b00;
        start = 1'b1;
        tick;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (caddr == 9'd100) seen = 1'b1;
            else tick;
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (!seen || state !== 2'b01 || caddr !== 9'd101) begin
            errors++;
            $display("FAIL start_ignored: state=%b addr=%0d, want 01/101", state, caddr);
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (caddr == 9'd200) seen = 1'b1;
            else tick;
        end
        abort = 1'b1;
        #1;
        checks++;
        if (!seen || crden !== 1'b0 || gwren !== 1'b0) begin
            errors++;
            $display("FAIL abort_strobes: rden=%b wren=%b, want 0/0", crden, gwren);
        end
        tick;
        abort = 1'b0;
        checks++;
        if (state !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: state=%b busy=%b, want 00/0", state, busy);
        end
        wc = wr_cnt;
        for (int i = 0; i < 8; i++) tick;
        checks++;
        if (wr_cnt !== wc || wc !== 197) begin
            errors++;
            $display("FAIL abort_writes: writes=%0d then %0d, want 197/197", wc, wr_cnt);
        end
        do_clr;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (state !== 2'b01 || caddr !== 9'd0 || crden !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: state=%b addr=%0d rden=%b, want 01/0/1", state, caddr, crden);
        end
        wait_done(600, ok);
        checks++;
        if (!ok || wr_cnt !== NP || ord_err !== 0) begin
            errors++;
            $display("FAIL restart_frame: done=%b writes=%0d order_err=%0d", ok, wr_cnt, ord_err);
        end
        do_ack;
    endtask

    task automatic test_async_reset;
        int wc;
        logic seen;
        do_clr;
        start = 1'b1;
        tick;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (caddr == 9'd100) seen = 1'b1;
            else tick;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (!seen || state !== 2'b00 || busy !== 1'b0 || crden !== 1'b0 || gwren !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctrl: state=%b busy=%b rden=%b wren=%b, want 0", state, busy, crden, gwren);
        end
        checks++;
        if (caddr !== 9'd0 || gaddr !== 9'd0 || gdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_data: caddr=%0d gaddr=%0d gdata=%h, want 0", caddr, gaddr, gdata);
        end
        tick;
        rst = 1'b0;
        wc = wr_cnt;
        for (int i = 0; i < 10; i++) tick;
        checks++;
        if (state !== 2'b00 || wr_cnt !== wc) begin
            errors++;
            $display("FAIL rst_quiet: state=%b writes %0d->%0d, want 00 and no writes", state, wc, wr_cnt);
        end
    endtask

    task automatic test_param5;
        logic [3:0] e5 [4];
        int n5;
        e5 = '{4'hF, 4'hF, 4'h8, 4'hF};
        cmem5[0] = 15'h7FFF;
        cmem5[1] = 15'h7FFF;
        cmem5[2] = {5'h10, 5'h10, 5'h10};
        cmem5[3] = 15'h7FFF;
        mode   = 2'b00;
        start5 = 1'b1;
        tick;
        start5 = 1'b0;
        n5 = 0;
        for (int i = 0; i < 20; i++) begin
            if (gwren5) begin
                n5++;
                checks++;
                if (gdata5 !== e5[gaddr5]) begin
                    errors++;
                    $display("FAIL p5_px%0d: data=%h, want %h", gaddr5, gdata5, e5[gaddr5]);
                end
            end
            tick;
        end
        checks++;
        if (n5 !== 4 || state5 !== 2'b11 || busy5 !== 1'b0) begin
            errors++;
            $display("FAIL p5_frame: writes=%0d state=%b busy=%b, want 4/11/0", n5, state5, busy5);
        end
        do_ack;
    endtask

    task automatic test_single_pixel;
        int n1;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        checks++;
        if (state1 !== 2'b01 || crden1 !== 1'b1 || caddr1 !== 1'b0) begin
            errors++;
            $display("FAIL n1_run: state=%b rden=%b, want 01/1", state1, crden1);
        end
        tick;
        checks++;
        if (state1 !== 2'b10 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_flush: state=%b busy=%b, want 10/1", state1, busy1);
        end
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (gwren1) begin
                n1++;
                checks++;
                if (gdata1 !== 8'h4D || gaddr1 !== 1'b0) begin
                    errors++;
                    $display("FAIL n1_px: data=%h addr=%0d, want 4d/0", gdata1, gaddr1);
                end
            end
            tick;
        end
        checks++;
        if (n1 !== 1 || state1 !== 2'b11) begin
            errors++;
            $display("FAIL n1_done: writes=%0d state=%b, want 1/11", n1, state1);
        end
        do_ack;
    endtask

    initial begin
        rst    = 1'b1;
        clr    = 1'b1;
        start  = 1'b0;
        start5 = 1'b0;
        start1 = 1'b0;
        hold   = 1'b0;
        abort  = 1'b0;
        ack    = 1'b0;
        mode   = 2'b00;
        load_pattern;
        tick;
        test_reset;
        test_luma;
        test_modes;
        test_full_frame;
        test_hold;
        test_abort;
        test_async_reset;
        test_param5;
        test_single_pixel;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
